mem_arbiter: RTL

Shared-memory controller for the core's single byte-wide RAM port. It arbitrates between the instruction fetcher (word reads) and the load/store unit (byte/half/word reads and writes). It serialises each granted access into one byte per cycle and returns the assembled little-endian result with a one-cycle ready pulse. It sits between both requesters and the top-level RAM/IO bus.

---
 rtl/mem_arbiter_if.sv | 31 +++
 rtl/mem_arbiter.sv | 121 ++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester handshakes plus the byte-wide RAM/IO bus around mem_arbiter.
// master = the arbiter, slave = the requesters and memory that surround it.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  rdy;
    logic                  if_valid;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_ready;
    logic [31:0]           if_data;
    logic                  ls_valid;
    logic                  ls_wr;
    logic [1:0]            ls_size;
    logic [ADDR_WIDTH-1:0] ls_addr;
    logic [31:0]           ls_wdata;
    logic                  ls_ready;
    logic [31:0]           ls_rdata;
    logic [7:0]            mem_din;
    logic [7:0]            mem_dout;
    logic [ADDR_WIDTH-1:0] mem_a;
    logic                  mem_wr;
    logic                  io_buffer_full;
    modport master (
        input  rdy, if_valid, if_addr, ls_valid, ls_wr, ls_size, ls_addr, ls_wdata, mem_din, io_buffer_full,
        output if_ready, if_data, ls_ready, ls_rdata, mem_dout, mem_a, mem_wr
    );
    modport slave (
        output rdy, if_valid, if_addr, ls_valid, ls_wr, ls_size, ls_addr, ls_wdata, mem_din, io_buffer_full,
        input  if_ready, if_data, ls_ready, ls_rdata, mem_dout, mem_a, mem_wr
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: grants fetch or load/store, serialises the access one byte per cycle on the RAM port.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin grant; otherwise load/store has fixed priority.
module mem_arbiter #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] IO_BASE    = ADDR_WIDTH'(32'h30000)
) (
    input logic           clk,
    input logic           rst,
    mem_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
    state_t                state_q;
    logic [ADDR_WIDTH-1:0] addr_q, mem_a_q;
    logic [31:0]           wdata_q, if_data_q, ls_rdata_q, done_data;
    logic [23:0]           buf_q, buf_d;
    logic [7:0]            mem_dout_q;
    logic [1:0]            a_q, n_q, di_q, nxt, ls_last;
    logic                  owner_q, dv_q, if_ready_q, ls_ready_q;
    logic                  req_if, req_ls, grant_ls, io_stall, rd_done;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic                  lg_q;
`endif
    always_comb begin
        nxt       = a_q + 2'd1;
        ls_last   = bus.ls_size == 2'd0 ? 2'd0 : bus.ls_size == 2'd1 ? 2'd1 : 2'd3;
        req_if    = bus.if_valid && !if_ready_q;
        req_ls    = bus.ls_valid && !ls_ready_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        grant_ls  = req_ls && (!req_if || !lg_q);
`else
        grant_ls  = req_ls;
`endif
        io_stall  = mem_a_q >= IO_BASE && bus.io_buffer_full;
        rd_done   = state_q == READ && bus.rdy && dv_q && di_q == n_q;
        done_data = n_q == 2'd0 ? {24'd0, bus.mem_din} :
                    n_q == 2'd1 ? {16'd0, bus.mem_din, buf_q[7:0]} : {bus.mem_din, buf_q};
        buf_d     = buf_q;
        if (state_q == READ && dv_q) begin
            buf_d[7:0]   = di_q == 2'd0 ? bus.mem_din : buf_q[7:0];
            buf_d[15:8]  = di_q == 2'd1 ? bus.mem_din : buf_q[15:8];
            buf_d[23:16] = di_q == 2'd2 ? bus.mem_din : buf_q[23:16];
        end
    end
    assign bus.mem_wr   = state_q == WRITE && bus.rdy && !io_stall;
    assign bus.mem_a    = mem_a_q;
    assign bus.mem_dout = mem_dout_q;
    assign bus.if_ready = if_ready_q;
    assign bus.if_data  = if_data_q;
    assign bus.ls_ready = ls_ready_q;
    assign bus.ls_rdata = ls_rdata_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            mem_a_q    <= '0;
            mem_dout_q <= '0;
            wdata_q    <= '0;
            if_data_q  <= '0;
            ls_rdata_q <= '0;
            buf_q      <= '0;
            a_q        <= '0;
            n_q        <= '0;
            di_q       <= '0;
            dv_q       <= 1'b0;
            owner_q    <= 1'b0;
            if_ready_q <= 1'b0;
            ls_ready_q <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            lg_q       <= 1'b0;
`endif
        end else begin
            // mem_din always answers last cycle's mem_a, so this tracking runs even while frozen
            dv_q  <= state_q == READ;
            di_q  <= a_q;
            buf_q <= buf_d;
            if (bus.rdy) begin
                if_ready_q <= 1'b0;
                ls_ready_q <= 1'b0;
                case (state_q)
                    IDLE: if (req_if || req_ls) begin
                        owner_q    <= grant_ls;
                        addr_q     <= grant_ls ? bus.ls_addr : bus.if_addr;
                        mem_a_q    <= grant_ls ? bus.ls_addr : bus.if_addr;
                        n_q        <= grant_ls ? ls_last : 2'd3;
                        a_q        <= 2'd0;
                        wdata_q    <= bus.ls_wdata;
                        mem_dout_q <= bus.ls_wdata[7:0];
                        state_q    <= grant_ls && bus.ls_wr ? WRITE : READ;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        lg_q       <= grant_ls;
`endif
                    end
                    READ: begin
                        if (a_q != n_q) begin
                            a_q     <= nxt;
                            mem_a_q <= addr_q + ADDR_WIDTH'(nxt);
                        end
                        if (rd_done) begin
                            state_q    <= IDLE;
                            ls_ready_q <= owner_q;
                            if_ready_q <= !owner_q;
                            ls_rdata_q <= owner_q ? done_data : ls_rdata_q;
                            if_data_q  <= owner_q ? if_data_q : done_data;
                        end
                    end
                    WRITE: if (!io_stall) begin
                        if (a_q == n_q) begin
                            state_q    <= IDLE;
                            ls_ready_q <= 1'b1;
                        end else begin
                            a_q        <= nxt;
                            mem_a_q    <= addr_q + ADDR_WIDTH'(nxt);
                            mem_dout_q <= wdata_q[{nxt, 3'b000} +: 8];
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
endmodule
